// File: rtl/mmio_uart_transmitter.sv
// Memory-mapped UART transmitter: stores to the data address queue bytes in a FIFO,
// which an 8N1 serialiser drains LSB first; loads return a status word after a one-cycle stall.
module mmio_uart_transmitter #(
  parameter int          CLKS_PER_BIT    = 868,
  parameter int          FIFO_DEPTH_LOG2 = 2,
  parameter logic [31:0] TX_DATA_ADDRESS = 32'h2000,
  parameter logic [31:0] STATUS_ADDRESS  = 32'h2004
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        opcode_is_load,
  input  logic        opcode_is_store,
  input  logic [31:0] effective_address,
  input  logic [31:0] store_data,
  output logic        address_hit,
  output logic        clk_stall,
  output logic [31:0] result_to_write_rd,
  output logic        uart_tx
);

  localparam int DEPTH = 1 << FIFO_DEPTH_LOG2;
  localparam int CW    = FIFO_DEPTH_LOG2 + 1;
  localparam int BW    = $clog2(CLKS_PER_BIT);
  localparam logic [BW-1:0] BAUD_MAX = BW'(CLKS_PER_BIT - 1);

  typedef struct packed {
    logic        ld;
    logic        st;
    logic [31:0] addr;
    logic [7:0]  data;
  } mmio_req_t;

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} tx_state_t;

  mmio_req_t req;
  logic      hit_tx, hit_st;
  logic      unused_data;

  assign req         = '{ld: opcode_is_load, st: opcode_is_store,
                         addr: effective_address, data: store_data[7:0]};
  assign unused_data = ^store_data[31:8];
  assign hit_tx      = (req.addr == TX_DATA_ADDRESS);
  assign hit_st      = (req.addr == STATUS_ADDRESS);
  assign address_hit = (req.ld | req.st) & (hit_tx | hit_st);

  // FIFO
  logic [DEPTH-1:0][7:0]      fifo_mem;
  logic [FIFO_DEPTH_LOG2-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0]              count;
  logic                       fifo_full, store_push, store_full_stall, pop;

  // Full is judged on the registered count, so a pop in the same cycle does not free the slot.
  assign fifo_full        = (count == CW'(DEPTH));
  assign store_push       = req.st & hit_tx & ~fifo_full;
  assign store_full_stall = req.st & hit_tx & fifo_full;

  always_ff @(posedge clk) begin
    if (store_push) fifo_mem[wr_ptr] <= req.data;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (store_push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)        rd_ptr <= rd_ptr + 1'b1;
      case ({store_push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // Transmit FSM
  tx_state_t     state, state_nx;
  logic [BW-1:0] baud, baud_nx;
  logic [2:0]    bit_idx, bit_nx;
  logic [7:0]    shift, shift_nx;
  logic          tx_q, tx_nx, bit_end, tx_busy;

  assign bit_end = (baud == '0);
  assign tx_busy = (state != IDLE) | (count != '0);

  always_comb begin
    state_nx = state;
    baud_nx  = baud;
    bit_nx   = bit_idx;
    shift_nx = shift;
    pop      = 1'b0;
    case (state)
      IDLE: begin
        if (count != '0) begin
          pop      = 1'b1;
          shift_nx = fifo_mem[rd_ptr];
          baud_nx  = BAUD_MAX;
          state_nx = START;
        end
      end
      START: begin
        if (bit_end) begin
          state_nx = DATA;
          bit_nx   = 3'd0;
          baud_nx  = BAUD_MAX;
        end else baud_nx = baud - BW'(1);
      end
      DATA: begin
        if (bit_end) begin
          baud_nx = BAUD_MAX;
          if (bit_idx == 3'd7) state_nx = STOP;
          else                 bit_nx   = bit_idx + 3'd1;
        end else baud_nx = baud - BW'(1);
      end
      STOP: begin
        if (bit_end) begin
          // Chain straight into the next start bit so queued frames leave without an idle gap.
          if (count != '0) begin
            pop      = 1'b1;
            shift_nx = fifo_mem[rd_ptr];
            baud_nx  = BAUD_MAX;
            state_nx = START;
          end else state_nx = IDLE;
        end else baud_nx = baud - BW'(1);
      end
      default: state_nx = IDLE;
    endcase
  end

  always_comb begin
    tx_nx = 1'b1;
    case (state)
      START:   tx_nx = 1'b0;
      DATA:    tx_nx = shift[bit_idx];
      default: tx_nx = 1'b1;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state   <= IDLE;
      baud    <= '0;
      bit_idx <= '0;
      shift   <= '0;
      tx_q    <= 1'b1;
    end else begin
      state   <= state_nx;
      baud    <= baud_nx;
      bit_idx <= bit_nx;
      shift   <= shift_nx;
      tx_q    <= tx_nx;
    end
  end

  assign uart_tx = tx_q;

  // Load path: stall one cycle, then latch the result and release the core.
  logic        load_in_progress, load_stall_reg, ld_status_q, load_start;
  logic [31:0] status_word;

  assign load_start  = req.ld & (hit_tx | hit_st) & ~load_in_progress;
  assign status_word = {24'b0, 4'(count), 2'b0, fifo_full, tx_busy};

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      load_in_progress   <= 1'b0;
      load_stall_reg     <= 1'b0;
      ld_status_q        <= 1'b0;
      result_to_write_rd <= '0;
    end else begin
      load_in_progress <= load_start;
      load_stall_reg   <= load_start;
      if (load_start) ld_status_q <= hit_st;
      if (load_in_progress) result_to_write_rd <= ld_status_q ? status_word : 32'b0;
    end
  end

  assign clk_stall = load_stall_reg | store_full_stall;

endmodule

// File: tb/tb_mmio_uart_transmitter.sv
// Directed bench for mmio_uart_transmitter: a line decoder checks every frame against a
// queue of expected bytes filled as stores are accepted.
module tb_mmio_uart_transmitter;
  localparam int CPB = 4;
  localparam logic [31:0] TXA = 32'h2000;
  localparam logic [31:0] STA = 32'h2004;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        opcode_is_load, opcode_is_store;
  logic [31:0] effective_address, store_data;
  logic        address_hit, clk_stall, uart_tx;
  logic [31:0] result_to_write_rd;

  int total = 0;
  int bad   = 0;

  logic [7:0]  exp_q[$];
  int unsigned starts[$];
  int unsigned cyc = 0;
  int          dec_st = 0;
  int          dec_cnt = 0;
  logic [7:0]  dec_sh = 8'h00;

  mmio_uart_transmitter #(.CLKS_PER_BIT(CPB), .FIFO_DEPTH_LOG2(2),
                          .TX_DATA_ADDRESS(TXA), .STATUS_ADDRESS(STA)) dut (
    .clk(clk), .reset_n(reset_n),
    .opcode_is_load(opcode_is_load), .opcode_is_store(opcode_is_store),
    .effective_address(effective_address), .store_data(store_data),
    .address_hit(address_hit), .clk_stall(clk_stall),
    .result_to_write_rd(result_to_write_rd), .uart_tx(uart_tx)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Serial decoder: samples mid-bit on falling clock edges.
  always @(negedge clk) begin
    cyc++;
    if (!reset_n) dec_st = 0;
    else if (dec_st == 0) begin
      if (uart_tx === 1'b0) begin
        dec_st  = 1;
        dec_cnt = 0;
        starts.push_back(cyc);
      end
    end else begin
      dec_cnt++;
      if (dec_cnt % CPB == CPB / 2) begin
        int j;
        j = dec_cnt / CPB;
        if (j == 0) chk("start_bit", 32'(uart_tx), 32'd0);
        else if (j <= 8) dec_sh[j-1] = uart_tx;
        else begin
          chk("stop_bit", 32'(uart_tx), 32'd1);
          if (exp_q.size() == 0) begin
            total++;
            bad++;
            $error("FAIL frame_unexpected observed=%h expected=none", dec_sh);
          end else chk("frame", 32'(dec_sh), 32'(exp_q.pop_front()));
          dec_st = 0;
        end
      end
    end
  end

  task automatic do_store(input logic [31:0] a, input logic [7:0] d,
                          output int stalls, output logic hit);
    opcode_is_store   = 1'b1;
    effective_address = a;
    store_data        = {24'h5A5A5A, d};
    stalls            = 0;
    @(negedge clk);
    hit = address_hit;
    while (clk_stall && stalls < 2000) begin
      stalls++;
      @(negedge clk);
    end
    if (a == TXA) exp_q.push_back(d);
    @(posedge clk);
    #1;
    opcode_is_store   = 1'b0;
    effective_address = '0;
    store_data        = '0;
  endtask

  task automatic do_load(input logic [31:0] a, output logic [31:0] res,
                         output int stalls, output logic hit);
    opcode_is_load    = 1'b1;
    effective_address = a;
    stalls            = 0;
    @(negedge clk);
    hit = address_hit;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk);
      #1;
      if (clk_stall) stalls++;
      else break;
    end
    res               = result_to_write_rd;
    opcode_is_load    = 1'b0;
    effective_address = '0;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int          st;
    logic        hit;
    logic [31:0] res;
    logic [9:0]  fr;
    logic [7:0]  b;

    opcode_is_load = 0; opcode_is_store = 0; effective_address = 0; store_data = 0;
    reset_n = 1'b1;
    #3 reset_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_tx", 32'(uart_tx), 32'd1);
    chk("rst_stall", 32'(clk_stall), 32'd0);
    chk("rst_result", result_to_write_rd, 32'd0);
    chk("rst_hit", 32'(address_hit), 32'd0);
    reset_n = 1'b1;
    @(posedge clk);
    #1;

    // Single frame, exact waveform
    b = 8'hA5;
    fr = {1'b1, b, 1'b0};
    do_store(TXA, b, st, hit);
    chk("t1_stall", 32'(st), 32'd0);
    chk("t1_hit", 32'(hit), 32'd1);
    for (int i = 0; i < 46; i++) begin
      @(negedge clk);
      if (i < 2 || i >= 42) chk("t1_idle", 32'(uart_tx), 32'd1);
      else chk("t1_wave", 32'(uart_tx), 32'(fr[(i-2)/CPB]));
    end
    repeat (5) @(posedge clk);
    #1;

    // Back-to-back stores; the first byte drains at the next edge, so the sixth finds it full
    starts.delete();
    for (int i = 1; i <= 5; i++) begin
      do_store(TXA, 8'(i), st, hit);
      chk("t2_nostall", 32'(st), 32'd0);
    end
    do_store(TXA, 8'h06, st, hit);
    chk("t6_full_stall", 32'(st), 32'd37);
    do_load(STA, res, st, hit);
    chk("t6_ld_stall", 32'(st), 32'd1);
    chk("t6_status", res, 32'h0000_0043);
    repeat (260) @(posedge clk);
    #1;
    chk("t2_q_empty", 32'(exp_q.size()), 32'd0);
    chk("t2_nframes", 32'(starts.size()), 32'd6);
    for (int i = 1; i < 6 && i < starts.size(); i++)
      chk("t2_gapfree", starts[i] - starts[i-1], 32'(10 * CPB));

    // Status during transmission
    do_store(TXA, 8'h3C, st, hit);
    do_store(TXA, 8'hC3, st, hit);
    do_store(TXA, 8'h81, st, hit);
    do_load(STA, res, st, hit);
    chk("t3_ld_hit", 32'(hit), 32'd1);
    chk("t3_ld_stall", 32'(st), 32'd1);
    chk("t3_status", res, 32'h0000_0021);
    repeat (140) @(posedge clk);
    #1;
    do_load(STA, res, st, hit);
    chk("t3_status_idle", res, 32'h0000_0000);

    // Non-transmitting accesses
    do_store(STA, 8'h77, st, hit);
    chk("t4_st_status_hit", 32'(hit), 32'd1);
    chk("t4_st_status_stall", 32'(st), 32'd0);
    do_load(TXA, res, st, hit);
    chk("t4_ld_data_hit", 32'(hit), 32'd1);
    chk("t4_ld_data_stall", 32'(st), 32'd1);
    chk("t4_ld_data", res, 32'd0);
    do_store(32'h3000, 8'h99, st, hit);
    chk("t4_other_hit", 32'(hit), 32'd0);
    chk("t4_other_stall", 32'(st), 32'd0);
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      chk("t4_line_idle", 32'(uart_tx), 32'd1);
    end
    @(posedge clk);
    #1;
    do_load(STA, res, st, hit);
    chk("t4_status", res, 32'd0);

    // Reset mid-frame with bytes queued
    for (int i = 0; i < 4; i++) do_store(TXA, 8'h00, st, hit);
    repeat (6) @(posedge clk);
    #1;
    chk("t5_pre_tx", 32'(uart_tx), 32'd0);
    #2;
    reset_n = 1'b0;
    exp_q.delete();
    #1;
    chk("t5_rst_tx", 32'(uart_tx), 32'd1);
    chk("t5_rst_stall", 32'(clk_stall), 32'd0);
    repeat (3) @(posedge clk);
    #2 reset_n = 1'b1;
    @(posedge clk);
    #1;
    do_load(STA, res, st, hit);
    chk("t5_status", res, 32'd0);
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      chk("t5_line_idle", 32'(uart_tx), 32'd1);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
